// File: rtl/rot_pkg.sv
// rot_pkg: shared widths, direction codes and output-stage state type for the rotate arbiter
package rot_pkg;
  localparam int DATA_W = 16;
  localparam int AMT_W = 4;
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT = 1'b1;
  typedef enum logic {EMPTY, FULL} out_state_t;
endpackage

// File: rtl/rot_arbiter_barrel_shift.sv
// Barrel_shift: combinational rotate-right of a DATA_W operand by amt bits
module Barrel_shift
  import rot_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [AMT_W-1:0]  amt,
  output logic [DATA_W-1:0] result
);
  logic [2*DATA_W-1:0] wide;
  // shifting the doubled word right leaves the rotated value in the low half
  always_comb begin
    wide = {data, data} >> amt;
    result = wide[DATA_W-1:0];
  end
endmodule

// File: rtl/rot_arbiter.sv
// rot_arbiter: two requesters share one rotate unit through round-robin grant and a one-entry output register
module rot_arbiter
  import rot_pkg::*;
#(
  parameter logic PRIO_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [AMT_W-1:0]  req0_amt,
  input  logic              req0_dir,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [AMT_W-1:0]  req1_amt,
  input  logic              req1_dir,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src
);
  out_state_t state, state_next;
  logic prio, grant, can_accept, accept, op_dir;
  logic [DATA_W-1:0] op_data, rot_data;
  logic [AMT_W-1:0] op_amt, eff_amt;
  // grant, handshake and operand mux; a left rotate is a right rotate by the negated amount
  always_comb begin
    grant = (req0_valid & req1_valid) ? prio : req1_valid;
    can_accept = ~rst & ((state == EMPTY) | out_ready);
    req0_ready = can_accept & ~grant;
    req1_ready = can_accept & grant;
    accept = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    op_data = grant ? req1_data : req0_data;
    op_amt = grant ? req1_amt : req0_amt;
    op_dir = grant ? req1_dir : req0_dir;
    eff_amt = (op_dir == DIR_LEFT) ? -op_amt : op_amt;
    out_valid = (state == FULL);
    state_next = accept ? FULL : (out_ready ? EMPTY : state);
  end
  Barrel_shift u_shift (
    .data   (op_data),
    .amt    (eff_amt),
    .result (rot_data)
  );
  // output-stage state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= EMPTY;
    else state <= state_next;
  // result capture and priority rotation on every accept
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_data <= '0;
      out_src <= 1'b0;
      prio <= PRIO_INIT;
    end else if (accept) begin
      out_data <= rot_data;
      out_src <= grant;
      prio <= ~grant;
    end
endmodule

// File: tb/tb_rot_arbiter.sv
// tb_rot_arbiter: directed table and sequence checks for rot_arbiter
module tb_rot_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic req0_valid, req0_ready, req0_dir, req1_valid, req1_ready, req1_dir;
  logic [15:0] req0_data, req1_data, out_data;
  logic [3:0] req0_amt, req1_amt;
  logic out_valid, out_ready, out_src;
  int total = 0, bad = 0;

  typedef struct {
    logic v0; logic [15:0] d0; logic [3:0] a0; logic r0;
    logic v1; logic [15:0] d1; logic [3:0] a1; logic r1;
    logic [15:0] exp_d; logic exp_s;
  } vec_t;
  vec_t vt[8];

  rot_arbiter #(.PRIO_INIT(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_amt(req0_amt), .req0_dir(req0_dir),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_amt(req1_amt), .req1_dir(req1_dir),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_src(out_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  initial begin
    vt[0] = '{1, 16'h1234, 4, 0, 0, 16'h0000, 0, 0, 16'h4123, 0};
    vt[1] = '{0, 16'h0000, 0, 0, 1, 16'h1234, 4, 1, 16'h2341, 1};
    vt[2] = '{0, 16'h0000, 0, 0, 1, 16'h1234, 0, 1, 16'h1234, 1};
    vt[3] = '{1, 16'h8001, 1, 1, 0, 16'hFFFF, 3, 0, 16'h0003, 0};
    vt[4] = '{1, 16'h0001, 15, 0, 0, 16'h0000, 0, 0, 16'h0002, 0};
    vt[5] = '{0, 16'h5555, 2, 1, 1, 16'hABCD, 8, 0, 16'hCDAB, 1};
    vt[6] = '{0, 16'h0000, 0, 0, 1, 16'hF000, 15, 1, 16'h7800, 1};
    vt[7] = '{1, 16'h00FF, 0, 0, 0, 16'h0000, 0, 0, 16'h00FF, 0};
    {req0_valid, req0_dir, req1_valid, req1_dir} = '0;
    {req0_data, req1_data, req0_amt, req1_amt} = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_src", out_src, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      {req0_valid, req0_data, req0_amt, req0_dir} = {vt[i].v0, vt[i].d0, vt[i].a0, vt[i].r0};
      {req1_valid, req1_data, req1_amt, req1_dir} = {vt[i].v1, vt[i].d1, vt[i].a1, vt[i].r1};
      #1;
      chk($sformatf("vec%0d_ready0", i), req0_ready, !vt[i].exp_s);
      chk($sformatf("vec%0d_ready1", i), req1_ready, vt[i].exp_s);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_data", i), out_data, vt[i].exp_d);
      chk($sformatf("vec%0d_src", i), out_src, vt[i].exp_s);
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain_empty", out_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    #1 rst = 1'b0;
    {req0_valid, req0_data, req0_amt, req0_dir} = {1'b1, 16'h1111, 4'd0, 1'b0};
    {req1_valid, req1_data, req1_amt, req1_dir} = {1'b1, 16'h2222, 4'd0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("alt%0d_ready0", i), req0_ready, (i % 2) == 0);
      chk($sformatf("alt%0d_ready1", i), req1_ready, (i % 2) == 1);
      @(posedge clk); #1;
      chk($sformatf("alt%0d_src", i), out_src, (i % 2) == 1);
      chk($sformatf("alt%0d_data", i), out_data, (i % 2) ? 16'h2222 : 16'h1111);
      @(negedge clk);
    end
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req0_data = 16'h5A5A + 16'(i);
      #1;
      chk($sformatf("stall%0d_ready0", i), req0_ready, 0);
      chk($sformatf("stall%0d_ready1", i), req1_ready, 0);
      @(posedge clk); #1;
      chk($sformatf("stall%0d_valid", i), out_valid, 1);
      chk($sformatf("stall%0d_data", i), out_data, 16'h2222);
      chk($sformatf("stall%0d_src", i), out_src, 1);
      @(negedge clk);
    end
    req0_data = 16'h1111;
    out_ready = 1'b1;
    #1;
    chk("release_ready0", req0_ready, 1);
    chk("release_ready1", req1_ready, 0);
    @(posedge clk); #1;
    chk("release_src", out_src, 0);
    chk("release_data", out_data, 16'h1111);
    @(negedge clk);
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_data", out_data, 0);
    chk("midrst_ready0", req0_ready, 0);
    chk("midrst_ready1", req1_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("postrst_ready0", req0_ready, 1);
    chk("postrst_ready1", req1_ready, 0);
    @(posedge clk); #1;
    chk("postrst_valid", out_valid, 1);
    chk("postrst_src", out_src, 0);
    chk("postrst_data", out_data, 16'h1111);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rot_arbiter.md
ROT_ARBITER -- requirements
Module: rot_arbiter

Interface
REQ-001 Parameter PRIO_INIT, default 0, meaning: requester holding priority after reset (0 or 1).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has a rotate operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle when high with req0_valid.
REQ-006 req0_data  input  16  requester 0 operand.
REQ-007 req0_amt  input  4  requester 0 rotate amount, 0-15.
REQ-008 req0_dir  input  1  requester 0 direction: 0 = rotate right, 1 = rotate left.
REQ-009 req1_valid, req1_ready, req1_data, req1_amt, req1_dir  same directions, widths and meanings as REQ-004..008, for requester 1.
REQ-010 out_valid  output  1  out_data/out_src hold a completed result.
REQ-011 out_ready  input  1  consumer accepts result when high with out_valid.
REQ-012 out_data  output  16  rotated result.
REQ-013 out_src  output  1  index of requester that issued the result.

Function
REQ-014 Block SHALL share one 16-bit rotate-right unit between two requesters via valid/ready handshakes.
REQ-015 Output stage SHALL be a one-entry register with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 can_accept SHALL equal (state==EMPTY) or (out_ready==1); reqN_ready SHALL be 0 whenever can_accept is 0.
REQ-017 Grant: only one valid requester -> it wins; both valid -> requester named by priority pointer wins; reqN_ready = can_accept AND grant==N, combinational.
REQ-018 At most one reqN_ready SHALL be high in any cycle.
REQ-019 On accept (reqN_valid & reqN_ready), priority pointer SHALL move to the other requester at that edge; with no accept, pointer SHALL hold.
REQ-020 Effective amount: dir=0 -> amt; dir=1 -> (16 - amt) mod 16 as 4-bit value; amt=0 gives 0 in both directions.
REQ-021 Result SHALL be registered at the accepting edge: out_valid=1 in the following cycle, latency 1 cycle from accept.
REQ-022 out_data, out_src SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 FULL with out_ready=1 and a new accept: entry SHALL be replaced at same edge, remaining FULL (one result per cycle sustained).
REQ-024 FULL with out_ready=1 and no accept -> EMPTY; EMPTY with accept -> FULL; otherwise state holds.
REQ-025 Requester inputs are sampled only at the accepting edge; values while ready=0 SHALL have no effect.

Reset
REQ-026 While rst=1: state=EMPTY, out_valid=0, out_data=16'h0000, out_src=0, priority pointer=PRIO_INIT, both reqN_ready=0.
REQ-027 Reset asserted mid-operation SHALL discard any held result immediately, with no output handshake completing.
REQ-028 First accept SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-029 Shared package rot_pkg SHALL hold DATA_W=16, AMT_W=4, DIR_RIGHT=0, DIR_LEFT=1 and the EMPTY/FULL state type.
REQ-030 Block SHALL instantiate exactly one Barrel_shift sub-module (16-bit data, 4-bit amt, rotate right) fed by the granted operand and effective amount.
REQ-031 Grant mux, direction conversion, pointer and output register SHALL live in rot_arbiter; no other sub-modules.

Verification
REQ-032 req0 data=16'h1234 amt=4 dir=0, out_ready=1 -> next cycle out_valid=1, out_data=16'h4123, out_src=0.
REQ-033 req1 data=16'h1234 amt=4 dir=1 -> out_data=16'h2341, out_src=1; amt=0 dir=1 -> out_data=16'h1234.
REQ-034 Both valid continuously, PRIO_INIT=0, out_ready=1 -> accepts alternate 0,1,0,1; out_src follows same order one cycle later.
REQ-035 out_ready=0 for 5 cycles while FULL -> out_data stable, both reqN_ready=0; out_ready=1 -> result accepted, next request accepted same cycle.
REQ-036 rst pulsed while FULL -> out_valid=0 and out_data=16'h0000 at once; after release, both valid -> requester PRIO_INIT granted first.
